// File: rtl/fft64_pkg.sv
// Shared constants, FSM state type and bin-order helper for the 64-point FFT output path.
package fft64_pkg;

  localparam int unsigned FFT_N     = 64;
  localparam int unsigned FFT_W     = 45;
  localparam int unsigned FFT_LOG2N = 6;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  // Mirror the six index bits (bit 0 <-> bit 5, ...).
  function automatic logic [5:0] bitrev6(input logic [5:0] v);
    logic [5:0] r;
    r = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      r[i] = v[5-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft64_frame_serializer.sv
// Buffers one parallel 64-bin complex FFT frame and streams it out one bin per beat.
// Build option: define FFT64_BITREV_EN to read the buffer in bit-reversed order
// (bin k is emitted from slot bitrev6(k)); otherwise bins leave in buffer order.
module fft64_frame_serializer
  import fft64_pkg::*;
#(
  parameter int unsigned N = FFT_N,
  parameter int unsigned W = FFT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*W-1:0]       in_re,
  input  logic [N*W-1:0]       in_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_re,
  output logic [W-1:0]         out_im,
  output logic [$clog2(N)-1:0] out_index,
  output logic                 out_last,
  output logic                 busy
);

  localparam int unsigned LN = $clog2(N);

  state_t        state;
  state_t        state_nx;
  logic [LN-1:0] idx;
  logic [LN-1:0] sel;
  logic          beat;
  logic          capture;
  logic [W-1:0]  frame_re [N];
  logic [W-1:0]  frame_im [N];

  // Buffer read address for the bin currently on the output.
  always_comb begin
`ifdef FFT64_BITREV_EN
    sel = bitrev6(idx);
`else
    sel = idx;
`endif
  end

  // Handshake, next-state and output decode.
  always_comb begin
    state_nx  = state;
    out_valid = (state == STREAM);
    busy      = (state == STREAM);
    out_last  = out_valid & (idx == LN'(N - 1));
    beat      = out_valid & out_ready;
    // Ready on the last beat as well, so a waiting frame follows without a bubble.
    in_ready  = (state == IDLE) | (beat & out_last);
    capture   = in_valid & in_ready;
    out_index = idx;
    out_re    = out_valid ? frame_re[sel] : '0;
    out_im    = out_valid ? frame_im[sel] : '0;
    case (state)
      IDLE:    if (capture) state_nx = STREAM;
      STREAM:  if (beat && out_last) state_nx = capture ? STREAM : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State and bin counter; the counter wraps naturally after bin N-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      if (capture) begin
        idx <= '0;
      end else if (beat) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Frame buffer, written only on a capture edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N; k++) begin
        frame_re[k] <= '0;
        frame_im[k] <= '0;
      end
    end else if (capture) begin
      for (int unsigned k = 0; k < N; k++) begin
        frame_re[k] <= in_re[k*W +: W];
        frame_im[k] <= in_im[k*W +: W];
      end
    end
  end

endmodule

// File: tb/tb_fft64_frame_serializer.sv
// Self-checking bench for fft64_frame_serializer: vector table, corner sequences,
// and random traffic against a queue-based reference of expected bins.
module tb_fft64_frame_serializer;

  localparam int unsigned N = 64;
  localparam int unsigned W = 45;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_re;
  logic [N*W-1:0] in_im;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_re;
  logic [W-1:0]   out_im;
  logic [5:0]     out_index;
  logic           out_last;
  logic           busy;

  always #5 clk = ~clk;

  fft64_frame_serializer #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_index(out_index), .out_last(out_last), .busy(busy)
  );

  typedef struct {
    logic [W-1:0] re;
    logic [W-1:0] im;
    int unsigned  idx;
    bit           last;
  } bin_t;

  typedef struct {
    int           kind;       // 0 ramp, 1 ramp with full-scale bin 5
    int           stall_at;   // beat held off, -1 for none
    int           stall_len;
    int           check_beat;
    int           exp_cycles;
    logic [W-1:0] exp_re;
    logic [W-1:0] exp_im;
  } vec_t;

  bin_t         q[$];         // bins still owed by the DUT, in emission order
  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] fre [N];
  logic [W-1:0] fim [N];
  logic [W-1:0] fs_neg;
  logic [W-1:0] fs_pos;
  vec_t         tbl [5];

  // Which stored bin is shown on beat k.
  function automatic int unsigned ref_sel(input int unsigned k);
    int unsigned r;
    r = k;
`ifdef FFT64_BITREV_EN
    r = 0;
    for (int unsigned b = 0; b < 6; b++) r = r * 2 + ((k >> b) & 1);
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_frame();
    for (int unsigned k = 0; k < N; k++) begin
      in_re[k*W +: W] = fre[k];
      in_im[k*W +: W] = fim[k];
    end
  endtask

  task automatic ramp_frame(input int base);
    for (int unsigned k = 0; k < N; k++) begin
      fre[k] = W'(base + int'(k));
      fim[k] = W'(-(base + int'(k)));
    end
  endtask

  // Compare this cycle against the reference, then advance one clock.
  task automatic step();
    int   sz;
    bit   mready;
    bit   mbeat;
    bit   mcap;
    bin_t b;
    #1;
    sz     = q.size();
    mready = (sz == 0) || (sz == 1 && out_ready);
    chk("in_ready", 64'(in_ready), 64'(mready));
    chk("out_valid", 64'(out_valid), 64'(sz > 0));
    chk("busy", 64'(busy), 64'(sz > 0));
    if (sz > 0) begin
      chk("out_re", 64'(out_re), 64'(q[0].re));
      chk("out_im", 64'(out_im), 64'(q[0].im));
      chk("out_index", 64'(out_index), 64'(q[0].idx));
      chk("out_last", 64'(out_last), 64'(q[0].last));
    end
    mbeat = (sz > 0) && out_ready;
    mcap  = in_valid && mready;
    @(posedge clk);
    if (mbeat) void'(q.pop_front());
    if (mcap) begin
      for (int unsigned k = 0; k < N; k++) begin
        b.re   = in_re[ref_sel(k)*W +: W];
        b.im   = in_im[ref_sel(k)*W +: W];
        b.idx  = k;
        b.last = (k == N - 1);
        q.push_back(b);
      end
    end
    #1;
  endtask

  task automatic drain();
    bit done;
    done      = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int g = 0; g < 200 && !done; g++) begin
      #1;
      if (out_valid && out_last) done = 1;
      step();
    end
    chk("drain_done", 64'(done), 64'd1);
  endtask

  task automatic run_frame(input vec_t v, output int cycles, output logic [W-1:0] gre,
                           output logic [W-1:0] gim);
    int beatn;
    int stalled;
    bit done;
    apply_frame();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    cycles   = 0;
    beatn    = 0;
    stalled  = 0;
    done     = 0;
    gre      = '0;
    gim      = '0;
    for (int g = 0; g < 300 && !done; g++) begin
      out_ready = !(beatn == v.stall_at && stalled < v.stall_len);
      if (!out_ready) stalled++;
      #1;
      if (out_valid) cycles++;
      if (out_valid && out_ready) begin
        if (beatn == v.check_beat) begin
          gre = out_re;
          gim = out_im;
        end
        if (out_last) done = 1;
        beatn++;
      end
      step();
    end
    chk("frame_done", 64'(done), 64'd1);
  endtask

  initial begin
    int           cyc;
    int           pulses;
    logic [W-1:0] gre;
    logic [W-1:0] gim;
    bit           seen_last;

    fs_neg = {1'b1, {(W-1){1'b0}}};
    fs_pos = {1'b0, {(W-1){1'b1}}};
`ifdef FFT64_BITREV_EN
    tbl[0] = '{0, -1, 0, 1, 64, W'(32), W'(-32)};
    tbl[1] = '{0, -1, 0, 2, 64, W'(16), W'(-16)};
    tbl[2] = '{0, 10, 5, 10, 69, W'(20), W'(-20)};
    tbl[3] = '{1, -1, 0, 40, 64, fs_neg, fs_pos};
`else
    tbl[0] = '{0, -1, 0, 1, 64, W'(1), W'(-1)};
    tbl[1] = '{0, -1, 0, 2, 64, W'(2), W'(-2)};
    tbl[2] = '{0, 10, 5, 10, 69, W'(10), W'(-10)};
    tbl[3] = '{1, -1, 0, 5, 64, fs_neg, fs_pos};
`endif
    tbl[4] = '{0, -1, 0, 63, 64, W'(63), W'(-63)};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_re     = '0;
    in_im     = '0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_re", 64'(out_re), 64'd0);
    chk("rst_out_im", 64'(out_im), 64'd0);
    chk("rst_out_index", 64'(out_index), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Vector table: content, ordering, stall and full-scale cases.
    for (int i = 0; i < 5; i++) begin
      ramp_frame(0);
      if (tbl[i].kind == 1) begin
        fre[5] = fs_neg;
        fim[5] = fs_pos;
      end
      run_frame(tbl[i], cyc, gre, gim);
      chk($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(tbl[i].exp_cycles));
      chk($sformatf("vec%0d_re", i), 64'(gre), 64'(tbl[i].exp_re));
      chk($sformatf("vec%0d_im", i), 64'(gim), 64'(tbl[i].exp_im));
      #1;
      chk($sformatf("vec%0d_idle_ready", i), 64'(in_ready), 64'd1);
      chk($sformatf("vec%0d_idle_busy", i), 64'(busy), 64'd0);
    end

    // Back-to-back frames: second frame queued with in_valid held high.
    ramp_frame(0);
    apply_frame();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    ramp_frame(100);
    apply_frame();
    pulses    = 0;
    seen_last = 0;
    for (int g = 0; g < 100 && !seen_last; g++) begin
      #1;
      if (in_ready) pulses++;
      if (out_valid && out_last) begin
        seen_last = 1;
        chk("b2b_last_re", 64'(out_re), 64'd63);
      end
      step();
    end
    in_valid = 1'b0;
    chk("b2b_ready_pulses", 64'(pulses), 64'd1);
    #1;
    chk("b2b_next_valid", 64'(out_valid), 64'd1);
    chk("b2b_next_re", 64'(out_re), 64'd100);
    chk("b2b_next_index", 64'(out_index), 64'd0);
    drain();

    // Reset asserted mid-frame at beat 30.
    ramp_frame(0);
    apply_frame();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int g = 0; g < 30; g++) step();
    #1;
    chk("pre_rst_index", 64'(out_index), 64'd30);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out_index", 64'(out_index), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ramp_frame(200);
    apply_frame();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    chk("post_rst_index", 64'(out_index), 64'd0);
    chk("post_rst_re", 64'(out_re), 64'(W'(200 + int'(ref_sel(0)))));
    drain();

    // Random traffic against the reference queue.
    for (int c = 0; c < 2000; c++) begin
      if (c % 8 == 0) begin
        for (int unsigned k = 0; k < N; k++) begin
          fre[k] = W'({$urandom(), $urandom()});
          fim[k] = W'({$urandom(), $urandom()});
        end
        apply_frame();
      end
      in_valid  = ($urandom_range(0, 2) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 200; c++) begin
      out_ready = 1'b1;
      step();
    end
    chk("final_empty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
